// File: rtl/dc_32to8_if.sv
// Word-side and byte-side handshake bundle for the 32->8 downsizer.
// The slave modport is the downsizer's view; master is the environment driving it.
interface dc_32to8_if;
  logic        s_vld_i;
  logic        s_rdy_o;
  logic [31:0] s_data_i;
  logic        s_sof_i;
  logic        s_eof_i;
  logic [1:0]  s_be_i;
  logic        m_vld_o;
  logic        m_rdy_i;
  logic [7:0]  m_data_o;
  logic        m_sof_o;
  logic        m_eof_o;

  modport slave (
    input  s_vld_i, s_data_i, s_sof_i, s_eof_i, s_be_i, m_rdy_i,
    output s_rdy_o, m_vld_o, m_data_o, m_sof_o, m_eof_o
  );

  modport master (
    output s_vld_i, s_data_i, s_sof_i, s_eof_i, s_be_i, m_rdy_i,
    input  s_rdy_o, m_vld_o, m_data_o, m_sof_o, m_eof_o
  );
endinterface

// File: rtl/dc_32to8.sv
// Width downsizer: 32-bit word stream with sof/eof/byte-index in, 8-bit byte stream out.
// One word register is drained a byte per cycle; the next word reloads on the final byte.
module dc_32to8 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input logic        clk,
  input logic        rst,
  dc_32to8_if.slave  bus
);

  logic        rst_r_q;
  logic        full_q, full_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic [1:0]  last_q, last_d;

  logic        wr, rd, done;
  logic [1:0]  sel;

  assign rd   = full_q & bus.m_rdy_i;
  assign done = rd & (idx_q == last_q);

  // rst is folded in so ready/valid are already low before the first edge of reset.
  assign bus.s_rdy_o = !rst & !rst_r_q & (!full_q | done);
  assign wr          = bus.s_vld_i & bus.s_rdy_o;

  assign sel          = MSB_FIRST ? (2'd3 - idx_q) : idx_q;
  assign bus.m_vld_o  = !rst & full_q;
  assign bus.m_data_o = rst ? '0 : data_q[{sel, 3'b000} +: 8];
  assign bus.m_sof_o  = !rst & full_q & sof_q & (idx_q == 2'd0);
  assign bus.m_eof_o  = !rst & full_q & eof_q & (idx_q == last_q);

  always_comb begin
    full_d = full_q;
    idx_d  = idx_q;
    data_d = data_q;
    sof_d  = sof_q;
    eof_d  = eof_q;
    last_d = last_q;
    if (wr) begin
      full_d = 1'b1;
      idx_d  = '0;
      data_d = bus.s_data_i;
      sof_d  = bus.s_sof_i;
      eof_d  = bus.s_eof_i;
      last_d = bus.s_eof_i ? bus.s_be_i : 2'd3;
    end else if (done) begin
      full_d = 1'b0;
      idx_d  = '0;
    end else if (rd) begin
      idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_r_q <= 1'b1;
      full_q  <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      last_q  <= 2'd3;
    end else begin
      rst_r_q <= 1'b0;
      full_q  <= full_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_dc_32to8.sv
// Directed and scoreboard-checked bench for dc_32to8 in both byte orders.
module tb_dc_32to8;
  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  dc_32to8_if a ();
  dc_32to8_if b ();

  dc_32to8 #(.MSB_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst0), .bus(a));
  dc_32to8 #(.MSB_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst1), .bus(b));

  typedef struct packed {
    logic [31:0] d;
    logic        sof;
    logic        eof;
    logic [1:0]  be;
  } word_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  word_t      wq[$];
  logic [9:0] obs[$];
  int         obs_cyc[$];
  int         acc_cyc[$];
  logic [9:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [10:0] prev_out = '0;

  // {sof, eof, data} for the T2..T4 stream
  logic [9:0] t2_exp [15] = '{10'h211, 10'h022, 10'h033, 10'h044, 10'h055, 10'h066,
                              10'h077, 10'h088, 10'h0AA, 10'h1BB, 10'h3EE, 10'h201,
                              10'h002, 10'h003, 10'h104};
  int t2_gap [4] = '{4, 4, 2, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // One clock of the dut0 stream engine: hold the head word until accepted, log bytes.
  task automatic tick(input bit rnd);
    logic [10:0] cur;
    @(negedge clk);
    a.s_vld_i = (wq.size() > 0);
    if (wq.size() > 0) begin
      a.s_data_i = wq[0].d;
      a.s_sof_i  = wq[0].sof;
      a.s_eof_i  = wq[0].eof;
      a.s_be_i   = wq[0].be;
    end
    a.m_rdy_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    cur = {a.m_vld_o, a.m_sof_o, a.m_eof_o, a.m_data_o};
    if (prev_stall) chk("stall_hold", 32'(cur), 32'(prev_out));
    prev_stall = a.m_vld_o & !a.m_rdy_i;
    prev_out   = cur;
    if (a.m_vld_o && a.m_rdy_i) begin
      obs.push_back(cur[9:0]);
      obs_cyc.push_back(cyc);
    end
    if (a.s_vld_i && a.s_rdy_o) begin
      void'(wq.pop_front());
      acc_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  function automatic logic [10:0] bout();
    return {b.m_vld_o, b.m_sof_o, b.m_eof_o, b.m_data_o};
  endfunction

  initial begin
    word_t w;
    bit    sof_next;
    int    last;

    rst0 = 1'b1; rst1 = 1'b1;
    a.s_vld_i = 1'b1; a.s_data_i = 32'hDEADBEEF; a.s_sof_i = 1'b1; a.s_eof_i = 1'b0;
    a.s_be_i = '0; a.m_rdy_i = 1'b1;
    b.s_vld_i = 1'b1; b.s_data_i = 32'hDEADBEEF; b.s_sof_i = 1'b1; b.s_eof_i = 1'b0;
    b.s_be_i = '0; b.m_rdy_i = 1'b1;

    // T1 reset
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t1_rst_rdy0", 32'(a.s_rdy_o), 0);
      chk("t1_rst_vld0", 32'(a.m_vld_o), 0);
      chk("t1_rst_rdy1", 32'(b.s_rdy_o), 0);
      chk("t1_rst_out1", 32'(bout()), 0);
    end
    @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    #1;
    chk("t1_post1_rdy0", 32'(a.s_rdy_o), 0);
    chk("t1_post1_rdy1", 32'(b.s_rdy_o), 0);
    chk("t1_post1_out0", 32'({a.m_vld_o, a.m_sof_o, a.m_eof_o, a.m_data_o}), 0);
    @(negedge clk);
    a.s_vld_i = 1'b0; b.s_vld_i = 1'b0;
    #1;
    chk("t1_post2_rdy0", 32'(a.s_rdy_o), 1);
    chk("t1_post2_rdy1", 32'(b.s_rdy_o), 1);
    chk("t1_post2_vld0", 32'(a.m_vld_o), 0);

    // T2..T4 streaming, partial last word, single-byte frame
    wq.push_back('{d: 32'h44332211, sof: 1'b1, eof: 1'b0, be: 2'd0});
    wq.push_back('{d: 32'h88776655, sof: 1'b0, eof: 1'b0, be: 2'd0});
    wq.push_back('{d: 32'hDDCCBBAA, sof: 1'b0, eof: 1'b1, be: 2'd1});
    wq.push_back('{d: 32'h000000EE, sof: 1'b1, eof: 1'b1, be: 2'd0});
    wq.push_back('{d: 32'h04030201, sof: 1'b1, eof: 1'b1, be: 2'd3});
    for (int i = 0; i < 40 && obs.size() < 15; i++) tick(1'b0);
    chk("t2_byte_count", 32'(obs.size()), 15);
    chk("t2_latency", 32'(obs_cyc.size() > 0 && acc_cyc.size() > 0 ? obs_cyc[0] - acc_cyc[0] : -1), 1);
    for (int i = 0; i < 15 && i < obs.size(); i++) begin
      chk($sformatf("t2_byte%0d", i), 32'(obs[i]), 32'(t2_exp[i]));
      chk($sformatf("t2_nobubble%0d", i), 32'(obs_cyc[i] - obs_cyc[0]), 32'(i));
    end
    chk("t2_accepts", 32'(acc_cyc.size()), 5);
    for (int i = 0; i < 4 && i + 1 < acc_cyc.size(); i++)
      chk($sformatf("t2_rdy_gap%0d", i), 32'(acc_cyc[i + 1] - acc_cyc[i]), 32'(t2_gap[i]));

    // T5 random backpressure against a byte scoreboard
    obs.delete(); obs_cyc.delete();
    sof_next = 1'b1;
    for (int n = 0; n < 64; n++) begin
      w.d   = $urandom;
      w.eof = ($urandom_range(0, 3) == 0);
      w.be  = 2'($urandom_range(0, 3));
      w.sof = sof_next;
      wq.push_back(w);
      last = w.eof ? int'(w.be) : 3;
      for (int k = 0; k <= last; k++)
        exp_q.push_back({w.sof && k == 0, w.eof && k == last, w.d[8*k +: 8]});
      sof_next = w.eof;
    end
    for (int i = 0; i < 3000 && obs.size() < exp_q.size(); i++) tick(1'b1);
    chk("t5_byte_count", 32'(obs.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      chk($sformatf("t5_byte%0d", i), 32'(obs[i]), 32'(exp_q[i]));

    // T6 MSB_FIRST=1 ordering and mid-word reset on dut1
    @(negedge clk);
    b.s_vld_i = 1'b1; b.s_data_i = 32'h11223344; b.s_sof_i = 1'b1; b.s_eof_i = 1'b0;
    #1 chk("t6_rdy", 32'(b.s_rdy_o), 1);
    @(negedge clk); b.s_vld_i = 1'b0; #1 chk("t6_b0", 32'(bout()), 32'h611);
    @(negedge clk); #1 chk("t6_b1", 32'(bout()), 32'h422);
    @(negedge clk); #1 chk("t6_b2", 32'(bout()), 32'h433);
    @(negedge clk);
    b.s_vld_i = 1'b1; b.s_sof_i = 1'b0;
    #1 chk("t6_b3", 32'(bout()), 32'h444);
    chk("t6_reload_rdy", 32'(b.s_rdy_o), 1);
    @(negedge clk); b.s_vld_i = 1'b0; #1 chk("t6_w2_b0", 32'(bout()), 32'h411);
    @(negedge clk); #1 chk("t6_w2_b1", 32'(bout()), 32'h422);
    @(negedge clk); rst1 = 1'b1; #1 chk("t6_rst_out", 32'(bout()), 0);
    @(negedge clk); rst1 = 1'b0;
    #1 chk("t6_after_rst_vld", 32'(b.m_vld_o), 0);
    chk("t6_after_rst_rdy", 32'(b.s_rdy_o), 0);
    @(negedge clk);
    b.s_vld_i = 1'b1; b.s_data_i = 32'hA1B2C3D4; b.s_sof_i = 1'b1; b.s_eof_i = 1'b1;
    b.s_be_i = 2'd2;
    #1 chk("t6_no_leftover", 32'(b.m_vld_o), 0);
    chk("t6_rdy_again", 32'(b.s_rdy_o), 1);
    @(negedge clk); b.s_vld_i = 1'b0; #1 chk("t6_w3_b0", 32'(bout()), 32'h6A1);
    @(negedge clk); #1 chk("t6_w3_b1", 32'(bout()), 32'h4B2);
    @(negedge clk); #1 chk("t6_w3_b2", 32'(bout()), 32'h5C3);
    @(negedge clk); #1 chk("t6_w3_trim", 32'(b.m_vld_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
